// File: rtl/hamming_arbiter.sv
// hamming_arbiter: round-robin front end that shares one hamming_decoder
// among NUM_REQ requesters and keeps saturating error statistics.
//
// Optional feature macro: HAMMING_ARB_TIMEOUT_EN
//   defined   -> WAIT aborts after TIMEOUT_CYCLES cycles without dec_done,
//                answering with rsp_timeout=1 and a zeroed payload.
//   undefined -> no timeout logic, rsp_timeout tied low, WAIT blocks forever.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid[NUM_REQ]        per-requester request level
//   req_data[32*NUM_REQ]      requester i codeword at [32i+31:32i]
//   req_ready[NUM_REQ]        one-hot accept pulse
//   rsp_valid[NUM_REQ]        one-hot result pulse to the owning requester
//   rsp_data[26], rsp_single, rsp_double, rsp_timeout
//                             last result, qualified only by rsp_valid
//   dec_start, dec_data[32]   request to the shared decoder
//   dec_decoded[26], dec_single, dec_double, dec_done
//                             decoder results
//   err_single_cnt, err_double_cnt [CNT_W]  saturating error counters
//   busy                      high whenever the FSM is not idle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | looking for a request, round-robin from rr_ptr
// ISSUE | one-cycle dec_start with the latched codeword
// WAIT  | waiting for dec_done (or timeout when enabled)
// RESP  | one-cycle rsp_valid to the granted requester, update stats
module hamming_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [25:0]            rsp_data,
  output logic                   rsp_single,
  output logic                   rsp_double,
  output logic                   rsp_timeout,
  output logic                   dec_start,
  output logic [31:0]            dec_data,
  input  logic [25:0]            dec_decoded,
  input  logic                   dec_single,
  input  logic                   dec_double,
  input  logic                   dec_done,
  output logic [CNT_W-1:0]       err_single_cnt,
  output logic [CNT_W-1:0]       err_double_cnt,
  output logic                   busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_q;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic             grant_found;
  logic             tmo_expired;

  // Rotating priority search; wraps naturally because NUM_REQ is a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr + IDX_W'(i);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    dec_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          state_d              = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dec_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (dec_done || tmo_expired) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_ptr         <= '0;
      gnt_q          <= '0;
      dec_data       <= '0;
      rsp_data       <= '0;
      rsp_single     <= 1'b0;
      rsp_double     <= 1'b0;
      err_single_cnt <= '0;
      err_double_cnt <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            gnt_q    <= grant_idx;
            dec_data <= req_data[32*grant_idx +: 32];
          end
        end
        S_WAIT: begin
          if (dec_done) begin
            rsp_data   <= dec_decoded;
            // A double error dominates: never report both flags.
            rsp_single <= dec_single & ~dec_double;
            rsp_double <= dec_double;
          end else if (tmo_expired) begin
            rsp_data   <= '0;
            rsp_single <= 1'b0;
            rsp_double <= 1'b0;
          end
        end
        S_RESP: begin
          rr_ptr <= gnt_q + IDX_W'(1);
          if (rsp_single && (err_single_cnt != '1))
            err_single_cnt <= err_single_cnt + CNT_W'(1);
          if (rsp_double && (err_double_cnt != '1))
            err_double_cnt <= err_double_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef HAMMING_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_q;

  // Loaded in ISSUE so the terminal count is hit on the last allowed WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (state_q == S_ISSUE)
        tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
      else if ((state_q == S_WAIT) && (tmo_cnt != '0))
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      if ((state_q == S_WAIT) && dec_done)
        tmo_q <= 1'b0;
      else if (tmo_expired)
        tmo_q <= 1'b1;
    end
  end

  assign tmo_expired = (state_q == S_WAIT) && !dec_done && (tmo_cnt == '0);
  assign rsp_timeout = tmo_q;
`else
  assign tmo_expired = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_arbiter.sv
module tb_hamming_arbiter;

  localparam int CNT_W = 2;
  localparam int TMO   = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [25:0]  rsp_data;
  logic         rsp_single, rsp_double, rsp_timeout;
  logic         dec_start;
  logic [31:0]  dec_data;
  logic [25:0]  dec_decoded;
  logic         dec_single, dec_double, dec_done;
  logic [CNT_W-1:0] err_single_cnt, err_double_cnt;
  logic         busy;

  hamming_arbiter #(.NUM_REQ(4), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_single(rsp_single), .rsp_double(rsp_double), .rsp_timeout(rsp_timeout),
    .dec_start(dec_start), .dec_data(dec_data),
    .dec_decoded(dec_decoded), .dec_single(dec_single), .dec_double(dec_double),
    .dec_done(dec_done),
    .err_single_cnt(err_single_cnt), .err_double_cnt(err_double_cnt),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_rr;
  int          m_single;
  int          m_double;
  logic [25:0] m_data;
  logic        m_sflag, m_dflag, m_tflag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int rr);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (rr + i) % 4;
      if (v[k]) return k;
    end
    return 0;
  endfunction

  function automatic int sat_inc(input int c);
    return (c < SAT) ? c + 1 : c;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_single = 0; m_double = 0;
    m_data = '0; m_sflag = 0; m_dflag = 0; m_tflag = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; req_valid = '0; dec_done = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_sgl_cnt"}, 32'(err_single_cnt), 32'(m_single));
    check({tag, "_dbl_cnt"}, 32'(err_double_cnt), 32'(m_double));
    check({tag, "_hold_data"}, 32'(rsp_data), 32'(m_data));
  endtask

  // One full transaction; caller keeps req_valid held afterwards.
  task automatic run_txn(input logic [3:0] v, input logic [127:0] data,
                         input logic [25:0] dout, input logic s, input logic d,
                         input int delay, input logic noise, output int g);
    @(negedge clk);
    dec_done = 0;
    req_valid = v; req_data = data;
    #1;
    check_idle_state("idle");
    g = pick(v, m_rr);
    check("ready", 32'(req_ready), 32'd1 << g);
    @(negedge clk);
    if (noise) begin
      dec_done = 1; dec_decoded = 26'($urandom); dec_single = 1; dec_double = 1;
    end
    #1;
    check("dec_start", 32'(dec_start), 1);
    check("dec_data", dec_data, data[32*g +: 32]);
    check("ready_issue", 32'(req_ready), 0);
    @(negedge clk);
    dec_done = 0;
    for (int k = 0; k <= delay; k++) begin
      #1;
      check("wait_rsp", 32'(rsp_valid), 0);
      check("wait_start", 32'(dec_start), 0);
      check("wait_busy", 32'(busy), 1);
      if (k == delay) begin
        dec_done = 1; dec_decoded = dout; dec_single = s; dec_double = d;
      end
      @(negedge clk);
    end
    dec_done = noise;
    dec_decoded = 26'($urandom);
    dec_single = 1; dec_double = 0;
    #1;
    m_data = dout; m_sflag = s & ~d; m_dflag = d; m_tflag = 0;
    if (m_sflag) m_single = sat_inc(m_single);
    if (m_dflag) m_double = sat_inc(m_double);
    m_rr = (g + 1) % 4;
    check("rsp_valid", 32'(rsp_valid), 32'd1 << g);
    check("rsp_data", 32'(rsp_data), 32'(dout));
    check("rsp_single", 32'(rsp_single), 32'(m_sflag));
    check("rsp_double", 32'(rsp_double), 32'(m_dflag));
    check("rsp_timeout", 32'(rsp_timeout), 0);
  endtask

  task automatic final_idle(input string tag);
    @(negedge clk);
    req_valid = '0; dec_done = 0;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_rsp"}, 32'(rsp_valid), 0);
    check_idle_state(tag);
  endtask

  initial begin
    int g;
    int exp_seq [5];
    logic [127:0] d;
    rst = 1; req_valid = '0; req_data = '0;
    dec_decoded = '0; dec_single = 0; dec_double = 0; dec_done = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp", 32'(rsp_valid), 0);
    check("rst_start", 32'(dec_start), 0);
    check("rst_dec_data", dec_data, 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_flags", {29'd0, rsp_single, rsp_double, rsp_timeout}, 0);
    check("rst_cnts", {28'd0, err_single_cnt, err_double_cnt}, 0);
    @(negedge clk);
    rst = 0;

    // no requests: stay idle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("noreq_ready", 32'(req_ready), 0);
      check("noreq_busy", 32'(busy), 0);
    end

    // single request
    d = '0; d[31:0] = 32'h12345678;
    run_txn(4'b0001, d, 26'h0987654, 0, 0, 2, 0, g);
    check("single_grant", g, 0);
    final_idle("single_end");

    // round robin with all requesters held
    do_reset();
    exp_seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_txn(4'b1111, d, 26'($urandom), 0, 0, 1, 0, g);
      check("rr_order", g, exp_seq[i]);
    end
    final_idle("rr_end");

    // error statistics
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_txn(4'b0010, d, 26'($urandom), 1, 0, 0, 0, g);
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    run_txn(4'b0010, d, 26'($urandom), 1, 1, 0, 0, g);
    check("both_dbl_flag", 32'(rsp_double), 1);
    check("both_sgl_flag", 32'(rsp_single), 0);
    final_idle("err_end");
    check("err_single_3", 32'(err_single_cnt), 3);
    check("err_double_1", 32'(err_double_cnt), 1);

    // saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_txn(4'b1000, d, 26'($urandom), 1, 0, 1, 1, g);
    end
    final_idle("sat_end");
    check("sat_single", 32'(err_single_cnt), SAT);

    // reset while waiting, then a stray dec_done
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100; req_data = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    rst = 1; req_valid = '0;
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_data", 32'(rsp_data), 0);
    dec_done = 1; dec_decoded = 26'h3ffffff; dec_single = 1; dec_double = 1;
    @(negedge clk);
    dec_done = 0;
    #1;
    check("stray_rsp", 32'(rsp_valid), 0);
    @(negedge clk); #1;
    check("stray_rsp2", 32'(rsp_valid), 0);
    check_idle_state("stray");
    run_txn(4'b1111, {$urandom, $urandom, $urandom, $urandom}, 26'($urandom), 0, 0, 0, 0, g);
    check("post_rst_grant", g, 0);
    final_idle("post_rst_end");

    // timeout behaviour
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100; req_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    req_valid = '0;
    #1;
    check("tmo_start", 32'(dec_start), 1);
`ifdef HAMMING_ARB_TIMEOUT_EN
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk); #1;
      check("tmo_wait_rsp", 32'(rsp_valid), 0);
      check("tmo_wait_busy", 32'(busy), 1);
    end
    @(negedge clk); #1;
    check("tmo_rsp", 32'(rsp_valid), 32'b0100);
    check("tmo_flag", 32'(rsp_timeout), 1);
    check("tmo_data", 32'(rsp_data), 0);
    check("tmo_flags", {30'd0, rsp_single, rsp_double}, 0);
    m_rr = 3; m_data = '0;
    final_idle("tmo_end");
`else
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      check("notmo_busy", 32'(busy), 1);
      check("notmo_rsp", 32'(rsp_valid), 0);
      check("notmo_flag", 32'(rsp_timeout), 0);
    end
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic [3:0] v;
      logic s_e, d_e;
      v = 4'($urandom_range(1, 15));
      s_e = 1'($urandom);
      d_e = ($urandom_range(0, 3) == 0);
      d = {$urandom, $urandom, $urandom, $urandom};
      run_txn(v, d, 26'($urandom), s_e, d_e, $urandom_range(0, 5), 1'($urandom), g);
      if ($urandom_range(0, 3) == 0) final_idle("rand_gap");
    end
    final_idle("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
